// File: rtl/seg_scan_display.sv
// ---------------------------------------------------------------------------
// seg_scan_display
//   Multiplexed common-cathode 7-segment driver. A binary value is captured
//   with a Load/Busy handshake and rendered as hex or decimal (sequential
//   double-dabble, one shift per clock) on N_DIGITS scanned digits. It also
//   supports leading-zero blanking and an all-dash overflow indication.
//
//   Ports:
//     CLK        system clock
//     Rstn       synchronous active-low reset
//     Value      binary value to display (VAL_W bits)
//     Mode       0 = hexadecimal, 1 = decimal
//     Blank_Lz   1 = blank leading zeros
//     Load       capture request (strobe or level)
//     Busy       high while a capture/conversion is in progress
//     Seg_Out    segments {dp,g,f,e,d,c,b,a}, active-high, registered
//     Cs_Out     digit selects, active-low one-hot, bit 0 = rightmost digit
//     Blink_Mask per-digit blink enable (only when SEG_BLINK_EN is defined)
//
//   Optional build macro: SEG_BLINK_EN adds Blink_Mask and the BLINK_DIV
//   blink-phase counter.
//
//   Handshake: Load is sampled only when Busy is low. A Load seen at an edge
//   with Busy low latches Value/Mode/Blank_Lz, and Busy is high from the next
//   cycle. Load while Busy is high is dropped, not queued. The falling edge
//   of Busy coincides with the atomic display-register update.
// ---------------------------------------------------------------------------
module seg_scan_display #(
    parameter int N_DIGITS = 4,
    parameter int VAL_W    = 16,
    parameter int SCAN_DIV = 200
`ifdef SEG_BLINK_EN
   ,parameter int BLINK_DIV = 250_000
`endif
) (
    input  logic                CLK,
    input  logic                Rstn,
    input  logic [VAL_W-1:0]    Value,
    input  logic                Mode,
    input  logic                Blank_Lz,
    input  logic                Load,
`ifdef SEG_BLINK_EN
    input  logic [N_DIGITS-1:0] Blink_Mask,
`endif
    output logic                Busy,
    output logic [7:0]          Seg_Out,
    output logic [N_DIGITS-1:0] Cs_Out
);

    // Decimal digits needed for 2^VAL_W-1 is floor(VAL_W*log10(2))+1.
    // The register is never narrower than the display, so every shown digit
    // has a BCD nibble behind it.
    localparam int BCD_NAT = (VAL_W * 301) / 1000 + 1;
    localparam int BCD_N   = (BCD_NAT > N_DIGITS) ? BCD_NAT : N_DIGITS;
    localparam int BCD_W   = 4 * BCD_N;
    localparam int HEX_W   = (VAL_W > 4 * N_DIGITS) ? VAL_W : 4 * N_DIGITS;
    localparam int CNT_W   = $clog2(VAL_W + 1);
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    // The captured Mode is carried by the state itself: S_HEX or S_DEC.
    typedef enum logic [1:0] {S_IDLE, S_HEX, S_DEC, S_FIN} state_t;

    state_t                    state_q, state_d;
    logic [VAL_W-1:0]          val_q;
    logic                      cap_blz;
    logic [BCD_W-1:0]          bcd_q, bcd_adj;
    logic [CNT_W-1:0]          cnt_q;
    logic [N_DIGITS-1:0][7:0]  disp_q, new_disp;
    logic [N_DIGITS-1:0][3:0]  dig;
    logic [HEX_W-1:0]          hex_pad;
    logic                      ovf, lz;
    logic [SCAN_W-1:0]         scan_cnt;
    logic [IDX_W-1:0]          dig_idx;
    logic [7:0]                seg_sel;

    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 8'h3F;  4'h1: glyph = 8'h06;
            4'h2: glyph = 8'h5B;  4'h3: glyph = 8'h4F;
            4'h4: glyph = 8'h66;  4'h5: glyph = 8'h6D;
            4'h6: glyph = 8'h7D;  4'h7: glyph = 8'h07;
            4'h8: glyph = 8'h7F;  4'h9: glyph = 8'h6F;
            4'hA: glyph = 8'h77;  4'hB: glyph = 8'h7C;
            4'hC: glyph = 8'h39;  4'hD: glyph = 8'h5E;
            4'hE: glyph = 8'h79;  default: glyph = 8'h71;
        endcase
    endfunction

    // ---------------- control FSM ----------------
    always_ff @(posedge CLK) begin
        if (!Rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Load) state_d = Mode ? S_DEC : S_HEX;
            S_HEX:   state_d = S_IDLE;
            S_DEC:   if (cnt_q == CNT_W'(VAL_W - 1)) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign Busy = (state_q != S_IDLE);

    // ---------------- double-dabble add-3 step ----------------
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_N; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // ---------------- digit extraction, overflow, blanking ----------------
    always_comb begin
        hex_pad = HEX_W'(val_q);
        dig     = '0;
        if (state_q == S_HEX) begin
            for (int i = 0; i < N_DIGITS; i++) dig[i] = hex_pad[4*i +: 4];
            ovf = |(hex_pad >> (4 * N_DIGITS));
        end else begin
            for (int i = 0; i < N_DIGITS; i++) dig[i] = bcd_q[4*i +: 4];
            ovf = |(bcd_q >> (4 * N_DIGITS));
        end
    end

    // Walk from the most-significant digit down; blanking stops at the first
    // nonzero digit and never reaches digit 0.
    always_comb begin
        new_disp = '0;
        lz       = cap_blz;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (ovf) begin
                new_disp[i] = 8'h40;
            end else if (lz && (dig[i] == 4'd0) && (i != 0)) begin
                new_disp[i] = 8'h00;
            end else begin
                new_disp[i] = glyph(dig[i]);
                lz          = 1'b0;
            end
        end
    end

    // ---------------- capture / conversion datapath ----------------
    // disp_q is written only in S_HEX or S_FIN, so the scan never sees a
    // partially converted value.
    always_ff @(posedge CLK) begin
        if (!Rstn) begin
            val_q   <= '0;
            cap_blz <= 1'b0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (Load) begin
                    val_q   <= Value;
                    cap_blz <= Blank_Lz;
                    bcd_q   <= '0;
                    cnt_q   <= '0;
                end
                S_DEC: begin
                    bcd_q <= {bcd_adj[BCD_W-2:0], val_q[VAL_W-1]};
                    val_q <= {val_q[VAL_W-2:0], 1'b0};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_HEX, S_FIN: disp_q <= new_disp;
                default: ;
            endcase
        end
    end

    // ---------------- optional blink ----------------
`ifdef SEG_BLINK_EN
    localparam int BLK_W = $clog2(BLINK_DIV);
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_phase;   // 0 = on, 1 = off

    always_ff @(posedge CLK) begin
        if (!Rstn) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BLK_W'(1);
        end
    end

    assign seg_sel = (blink_phase && Blink_Mask[dig_idx]) ? 8'h00 : disp_q[dig_idx];
`else
    assign seg_sel = disp_q[dig_idx];
`endif

    // ---------------- scan ----------------
    // Seg_Out and Cs_Out are both registered from the same dig_idx, so they
    // switch on the same edge and no digit shows its neighbour's segments.
    always_ff @(posedge CLK) begin
        if (!Rstn) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
            Seg_Out  <= 8'h00;
            Cs_Out   <= '1;
        end else begin
            Cs_Out  <= ~(N_DIGITS'(1) << dig_idx);
            Seg_Out <= seg_sel;
            if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                dig_idx  <= (dig_idx == IDX_W'(N_DIGITS - 1)) ? '0 : dig_idx + IDX_W'(1);
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_display
//   Directed self-checking bench for seg_scan_display (N_DIGITS=4, VAL_W=16,
//   SCAN_DIV=200). Inputs are driven and outputs sampled on the falling edge.
//   Expected glyphs are hand-computed from the glyph table.
// ---------------------------------------------------------------------------
module tb_seg_scan_display;

    logic        CLK = 1'b0;
    logic        Rstn = 1'b0;
    logic [15:0] Value = '0;
    logic        Mode = 1'b0;
    logic        Blank_Lz = 1'b0;
    logic        Load = 1'b0;
    logic        Busy;
    logic [7:0]  Seg_Out;
    logic [3:0]  Cs_Out;
`ifdef SEG_BLINK_EN
    logic [3:0]  Blink_Mask = 4'b0000;
`endif

    int n_vec = 0;
    int n_mis = 0;

    seg_scan_display #(.N_DIGITS(4), .VAL_W(16), .SCAN_DIV(200)) dut (
        .CLK(CLK),
        .Rstn(Rstn),
        .Value(Value),
        .Mode(Mode),
        .Blank_Lz(Blank_Lz),
        .Load(Load),
`ifdef SEG_BLINK_EN
        .Blink_Mask(Blink_Mask),
`endif
        .Busy(Busy),
        .Seg_Out(Seg_Out),
        .Cs_Out(Cs_Out)
    );

    // ---------------- clock / watchdog ----------------
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic start_load(input logic [15:0] v, input logic m, input logic b);
        Value    = v;
        Mode     = m;
        Blank_Lz = b;
        Load     = 1'b1;
        tick();
        Load     = 1'b0;
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (Busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Advances at least one cycle, then waits for the given digit select.
    task automatic wait_digit(input int d, output logic [7:0] seg, output logic found);
        logic [3:0] cs;
        cs    = ~(4'b0001 << d);
        found = 1'b0;
        seg   = 8'hxx;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (Cs_Out === cs) begin
                found = 1'b1;
                seg   = Seg_Out;
                break;
            end
        end
    endtask

    function automatic int cs_index(input logic [3:0] cs);
        cs_index = -1;
        for (int i = 0; i < 4; i++) if (cs == ~(4'b0001 << i)) cs_index = i;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [3:0] exp_cs [5];
        logic bad_cs, bad_seg;
        repeat (2) tick();
        n_vec++; if (Busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_vec++; if (Seg_Out !== 8'h00) begin n_mis++; $display("FAIL reset_seg: got %h want 00", Seg_Out); end
        n_vec++; if (Cs_Out !== 4'b1111) begin n_mis++; $display("FAIL reset_cs: got %b want 1111", Cs_Out); end
        Rstn = 1'b1;
        repeat (300) tick();
        // reset held for 3 cycles in the middle of a digit slot
        Rstn = 1'b0;
        bad_cs = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (Cs_Out !== 4'b1111 || Seg_Out !== 8'h00 || Busy !== 1'b0) bad_cs = 1'b1;
        end
        n_vec++; if (bad_cs) begin n_mis++; $display("FAIL reset_hold: got cs %b seg %h, want 1111/00", Cs_Out, Seg_Out); end
        Rstn = 1'b1;
        exp_cs[0] = 4'b1110; exp_cs[1] = 4'b1101; exp_cs[2] = 4'b1011; exp_cs[3] = 4'b0111;
        bad_seg = 1'b0;
        for (int p = 0; p < 4; p++) begin
            bad_cs = 1'b0;
            for (int i = 0; i < 200; i++) begin
                tick();
                if (Cs_Out !== exp_cs[p]) bad_cs = 1'b1;
                if (Seg_Out !== 8'h00) bad_seg = 1'b1;
            end
            n_vec++; if (bad_cs) begin n_mis++; $display("FAIL scan_slot%0d: got %b want %b for 200 cycles", p, Cs_Out, exp_cs[p]); end
        end
        tick();
        n_vec++; if (Cs_Out !== 4'b1110) begin n_mis++; $display("FAIL scan_wrap: got %b want 1110", Cs_Out); end
        n_vec++; if (bad_seg) begin n_mis++; $display("FAIL scan_blank: got seg %h want 00", Seg_Out); end
    endtask

    task automatic test_hex();
        logic [7:0] exp [4];
        logic [7:0] seg;
        logic found;
        exp[0] = 8'h4F; exp[1] = 8'h39; exp[2] = 8'h6D; exp[3] = 8'h77;  // A5C3
        start_load(16'hA5C3, 1'b0, 1'b0);
        n_vec++; if (Busy !== 1'b1) begin n_mis++; $display("FAIL hex_busy_hi: got %b want 1", Busy); end
        tick();
        n_vec++; if (Busy !== 1'b0) begin n_mis++; $display("FAIL hex_busy_lo: got %b want 0", Busy); end
        for (int d = 0; d < 4; d++) begin
            wait_digit(d, seg, found);
            n_vec++;
            if (!found || seg !== exp[d]) begin
                n_mis++; $display("FAIL hex_digit%0d: got %h (found %0b) want %h", d, seg, found, exp[d]);
            end
        end
    endtask

    task automatic test_decimal();
        logic [7:0] old [4];
        logic [7:0] exp [4];
        logic [7:0] seg;
        logic found, early;
        int cnt, k;
        old[0] = 8'h4F; old[1] = 8'h39; old[2] = 8'h6D; old[3] = 8'h77;
        exp[0] = 8'h66; exp[1] = 8'h4F; exp[2] = 8'h5B; exp[3] = 8'h06;  // 1234
        start_load(16'd1234, 1'b1, 1'b0);
        cnt = 0; early = 1'b0;
        while (Busy === 1'b1 && cnt < 40) begin
            cnt++;
            k = cs_index(Cs_Out);
            if (k < 0 || Seg_Out !== old[k]) early = 1'b1;
            tick();
        end
        n_vec++; if (cnt != 17) begin n_mis++; $display("FAIL dec_busy_len: got %0d want 17", cnt); end
        n_vec++; if (early) begin n_mis++; $display("FAIL dec_no_early: got seg %h cs %b, want old glyphs while busy", Seg_Out, Cs_Out); end
        for (int d = 0; d < 4; d++) begin
            wait_digit(d, seg, found);
            n_vec++;
            if (!found || seg !== exp[d]) begin
                n_mis++; $display("FAIL dec_digit%0d: got %h (found %0b) want %h", d, seg, found, exp[d]);
            end
        end
    endtask

    task automatic test_blank_lz();
        logic [7:0] exp [4];
        logic [7:0] seg;
        logic found, ok;
        start_load(16'd7, 1'b1, 1'b1);
        wait_idle(ok);
        n_vec++; if (!ok) begin n_mis++; $display("FAIL lz7_idle: got busy %b want 0", Busy); end
        exp[0] = 8'h07; exp[1] = 8'h00; exp[2] = 8'h00; exp[3] = 8'h00;
        for (int d = 0; d < 4; d++) begin
            wait_digit(d, seg, found);
            n_vec++;
            if (!found || seg !== exp[d]) begin
                n_mis++; $display("FAIL lz7_digit%0d: got %h (found %0b) want %h", d, seg, found, exp[d]);
            end
        end
        start_load(16'd0, 1'b1, 1'b1);
        wait_idle(ok);
        n_vec++; if (!ok) begin n_mis++; $display("FAIL lz0_idle: got busy %b want 0", Busy); end
        exp[0] = 8'h3F;
        for (int d = 0; d < 4; d++) begin
            wait_digit(d, seg, found);
            n_vec++;
            if (!found || seg !== exp[d]) begin
                n_mis++; $display("FAIL lz0_digit%0d: got %h (found %0b) want %h", d, seg, found, exp[d]);
            end
        end
    endtask

    task automatic test_overflow_busy_load();
        logic [7:0] seg;
        logic found;
        int cnt;
        start_load(16'd10000, 1'b1, 1'b0);
        cnt = 0;
        while (Busy === 1'b1 && cnt < 40) begin
            cnt++;
            if (cnt == 5) begin
                Value = 16'h0005; Mode = 1'b0; Load = 1'b1;
            end else begin
                Load = 1'b0;
            end
            tick();
        end
        Load = 1'b0;
        n_vec++; if (cnt != 17) begin n_mis++; $display("FAIL ovf_busy_len: got %0d want 17", cnt); end
        tick();
        n_vec++; if (Busy !== 1'b0) begin n_mis++; $display("FAIL ovf_not_queued: got busy %b want 0", Busy); end
        for (int d = 0; d < 4; d++) begin
            wait_digit(d, seg, found);
            n_vec++;
            if (!found || seg !== 8'h40) begin
                n_mis++; $display("FAIL ovf_digit%0d: got %h (found %0b) want 40", d, seg, found);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] exp [4];
        logic [7:0] seg;
        logic found, ok, leak;
        int cnt;
        start_load(16'd9999, 1'b1, 1'b0);
        cnt = 0;
        while (Busy === 1'b1 && cnt < 8) begin
            cnt++;
            if (cnt < 8) tick();
        end
        n_vec++; if (cnt != 8) begin n_mis++; $display("FAIL abort_reach8: got %0d busy cycles want 8", cnt); end
        Rstn = 1'b0;
        tick();
        Rstn = 1'b1;
        n_vec++; if (Busy !== 1'b0 || Cs_Out !== 4'b1111 || Seg_Out !== 8'h00) begin
            n_mis++; $display("FAIL abort_reset: got busy %b cs %b seg %h want 0/1111/00", Busy, Cs_Out, Seg_Out);
        end
        leak = 1'b0;
        for (int i = 0; i < 900; i++) begin
            tick();
            if (Seg_Out !== 8'h00 || Busy !== 1'b0) leak = 1'b1;
        end
        n_vec++; if (leak) begin n_mis++; $display("FAIL abort_no_result: got seg %h busy %b want 00/0", Seg_Out, Busy); end
        start_load(16'd42, 1'b1, 1'b1);
        wait_idle(ok);
        n_vec++; if (!ok) begin n_mis++; $display("FAIL d42_idle: got busy %b want 0", Busy); end
        exp[0] = 8'h5B; exp[1] = 8'h66; exp[2] = 8'h00; exp[3] = 8'h00;
        for (int d = 0; d < 4; d++) begin
            wait_digit(d, seg, found);
            n_vec++;
            if (!found || seg !== exp[d]) begin
                n_mis++; $display("FAIL d42_digit%0d: got %h (found %0b) want %h", d, seg, found, exp[d]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_hex();
        test_decimal();
        test_blank_lz();
        test_overflow_busy_load();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
